// File: rtl/cycle_lock_pkg.sv
// Shared definitions for the cycle-lock datapath (code entry front-end and pattern checker).
package cycle_lock_pkg;

  localparam int CODE_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    READY
  } entry_state_t;

  typedef logic [CODE_W-1:0] code_t;

endpackage

// File: rtl/entry_timeout_timer.sv
// Inactivity timer for partial code entries; expire flags the last idle cycle allowed.
module entry_timeout_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  output logic expire
);

  localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] count;

  // Parks at LAST so expire stays asserted until the owner reacts and clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || load) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + W'(1);
    end
  end

  assign expire = !clear && !load && (count == LAST);

endmodule

// File: rtl/code_entry_collector.sv
// Serial-to-parallel code entry collector with valid/ready hand-off to the pattern checker.
// Optional inactivity timeout is built when CODE_ENTRY_TIMEOUT_EN is defined.
module code_entry_collector #(
  parameter int CODE_W      = cycle_lock_pkg::CODE_W,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        bit_in,
  input  logic                        bit_valid,
  output logic [CODE_W-1:0]           code_out,
  output logic                        code_valid,
  input  logic                        code_ready,
  output logic [$clog2(CODE_W+1)-1:0] bit_count,
  output logic                        busy,
  output logic                        overrun,
  output logic                        timeout
);

  import cycle_lock_pkg::*;

  localparam int CNT_W = $clog2(CODE_W + 1);

  if (CODE_W < 2 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("code_entry_collector: CODE_W and TIMEOUT_CYC must be at least 2");
  end

  entry_state_t     state, state_next;
  logic [CODE_W-1:0] shift_q, shift_next;
  logic [CNT_W-1:0]  count_q, count_next;
  logic              overrun_next, timeout_next;
  logic              expire;

`ifdef CODE_ENTRY_TIMEOUT_EN
  entry_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (bit_valid),
    .clear (clear || (state != COLLECT)),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif

  // clear outranks everything; in READY a handshake outranks the overrun check.
  always_comb begin
    state_next   = state;
    shift_next   = shift_q;
    count_next   = count_q;
    overrun_next = 1'b0;
    timeout_next = 1'b0;
    if (clear) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bit_valid) begin
            shift_next = {shift_q[CODE_W-2:0], bit_in};
            count_next = CNT_W'(1);
            state_next = COLLECT;
          end
        end
        COLLECT: begin
          if (bit_valid) begin
            shift_next = {shift_q[CODE_W-2:0], bit_in};
            if (count_q != CNT_W'(CODE_W)) begin
              count_next = count_q + CNT_W'(1);
            end
            if (count_q == CNT_W'(CODE_W - 1)) begin
              state_next = READY;
            end
          end else if (expire) begin
            state_next   = IDLE;
            count_next   = '0;
            timeout_next = 1'b1;
          end
        end
        READY: begin
          if (code_ready) begin
            if (bit_valid) begin
              shift_next = {shift_q[CODE_W-2:0], bit_in};
              count_next = CNT_W'(1);
              state_next = COLLECT;
            end else begin
              count_next = '0;
              state_next = IDLE;
            end
          end else if (bit_valid) begin
            overrun_next = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_next;
      shift_q <= shift_next;
      count_q <= count_next;
      overrun <= overrun_next;
      timeout <= timeout_next;
    end
  end

  assign code_out   = shift_q;
  assign bit_count  = count_q;
  assign code_valid = (state == READY);
  assign busy       = (state == COLLECT);

endmodule

// File: tb/tb_code_entry_collector.sv
// Randomized and directed bench for code_entry_collector against a queue-based reference model.
module tb_code_entry_collector;

  localparam int CODE_W = 16;
  localparam int TO_CYC = 8;

  logic              clk = 1'b0;
  logic              rst, clear, bit_in, bit_valid, code_ready;
  logic [CODE_W-1:0] code_out;
  logic              code_valid, busy, overrun, timeout;
  logic [4:0]        bit_count;

  int tests_run    = 0;
  int tests_failed = 0;

  bit q[$];
  bit held;
  int idle;
  bit exp_over, exp_to;

  code_entry_collector #(
    .CODE_W     (CODE_W),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .code_out  (code_out),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .bit_count (bit_count),
    .busy      (busy),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] heldWord();
    logic [31:0] w = 0;
    foreach (q[i]) w = w * 2 + q[i];
    return w;
  endfunction

  function automatic void modelReset();
    q.delete();
    held = 0;
    idle = 0;
    exp_over = 0;
    exp_to = 0;
  endfunction

  function automatic void acceptBit(input bit b);
    q.push_back(b);
    idle = 0;
    if (q.size() == CODE_W) held = 1;
  endfunction

  function automatic void modelStep(input bit c, input bit bv, input bit b, input bit rdy);
    exp_over = 0;
    exp_to   = 0;
    if (c) begin
      q.delete();
      held = 0;
      idle = 0;
    end else if (held) begin
      if (rdy) begin
        held = 0;
        q.delete();
        if (bv) acceptBit(b);
      end else if (bv) begin
        exp_over = 1;
      end
    end else if (bv) begin
      acceptBit(b);
    end else if (q.size() > 0) begin
      idle++;
`ifdef CODE_ENTRY_TIMEOUT_EN
      if (idle == TO_CYC) begin
        q.delete();
        exp_to = 1;
      end
`endif
    end
  endfunction

  task automatic checkAll(input string ctx);
    checkOutput({ctx, ".code_valid"}, 32'(code_valid), 32'(held));
    checkOutput({ctx, ".bit_count"}, 32'(bit_count), 32'(q.size()));
    checkOutput({ctx, ".busy"}, 32'(busy), 32'(!held && q.size() > 0));
    checkOutput({ctx, ".overrun"}, 32'(overrun), 32'(exp_over));
    checkOutput({ctx, ".timeout"}, 32'(timeout), 32'(exp_to));
    if (held) checkOutput({ctx, ".code_out"}, 32'(code_out), heldWord());
  endtask

  task automatic applyStimulus(input string ctx, input bit c, input bit bv, input bit b, input bit rdy);
    clear      = c;
    bit_valid  = bv;
    bit_in     = b;
    code_ready = rdy;
    @(posedge clk);
    #1;
    modelStep(c, bv, b, rdy);
    checkAll(ctx);
  endtask

  task automatic sendWord(input string ctx, input logic [15:0] word, input int max_gap);
    for (int i = CODE_W - 1; i >= 0; i--) begin
      repeat ($urandom_range(max_gap, 0)) applyStimulus(ctx, 0, 0, 0, 0);
      applyStimulus(ctx, 0, 1, word[i], 0);
    end
  endtask

  task automatic checkResetOutputs(input string ctx);
    checkOutput({ctx, ".code_out"}, 32'(code_out), 0);
    checkOutput({ctx, ".code_valid"}, 32'(code_valid), 0);
    checkOutput({ctx, ".bit_count"}, 32'(bit_count), 0);
    checkOutput({ctx, ".busy"}, 32'(busy), 0);
    checkOutput({ctx, ".overrun"}, 32'(overrun), 0);
    checkOutput({ctx, ".timeout"}, 32'(timeout), 0);
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    code_ready = 1'b0;
    modelReset();
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b0;

    sendWord("basic", 16'hA5C3, 3);
    applyStimulus("basic_hs", 0, 0, 0, 1);

    sendWord("bp", 16'h1234, 2);
    for (int i = 0; i < 3; i++) applyStimulus("bp_overrun", 0, 1, 1'($urandom_range(1, 0)), 0);
    applyStimulus("bp_hold", 0, 0, 0, 0);
    applyStimulus("bp_hs", 0, 0, 0, 1);

    sendWord("simul", 16'hFFFF, 1);
    applyStimulus("simul_hs", 0, 1, 0, 1);
    applyStimulus("simul_clr", 1, 0, 0, 0);

    for (int i = 0; i < 7; i++) applyStimulus("clr_part", 0, 1, 1'(i), 0);
    applyStimulus("clr_bv", 1, 1, 1, 0);
    sendWord("clr_next", 16'h0F0F, 2);
    applyStimulus("clr_hs", 0, 0, 0, 1);

    sendWord("arst", 16'h5A5A, 0);
    #2 rst = 1'b1;
    #1 checkResetOutputs("arst");
    modelReset();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) applyStimulus("to_bits", 0, 1, 1, 0);
    for (int i = 0; i < TO_CYC; i++) applyStimulus("to_idle", 0, 0, 0, 0);
    applyStimulus("to_after", 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus("to2_bits", 0, 1, 0, 0);
    for (int i = 0; i < TO_CYC - 1; i++) applyStimulus("to2_idle", 0, 0, 0, 0);
    applyStimulus("to2_save", 0, 1, 1, 0);
    applyStimulus("to2_clr", 1, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      applyStimulus("rand",
                    $urandom_range(99, 0) < 3,
                    $urandom_range(99, 0) < 45,
                    1'($urandom_range(1, 0)),
                    $urandom_range(99, 0) < 25);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
